// File: rtl/tuner_pkg.sv
// tuner_pkg: shared constants and types for the tuner frame scheduler.
//   NUM_BINS / MAG_W : frame geometry; fixed to match the max_val unit.
//   sched_state_e    : scheduler FSM states.
//   Candidate code   : 4 bits; MSB=1 means a silent frame, otherwise the
//                      low 3 bits hold the winning bin index.
package tuner_pkg;

   localparam int NUM_BINS = 7;
   localparam int MAG_W    = 16;
   localparam int IDX_W    = 3;
   localparam int CAND_W   = 4;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      UPDATE  = 2'd3
   } sched_state_e;

   localparam logic [CAND_W-1:0] CAND_SILENT = 4'b1000;

   // Encode one frame outcome as a candidate code.
   function automatic logic [CAND_W-1:0] frame_result(input logic [IDX_W-1:0] idx,
                                                      input logic             silent);
      return silent ? CAND_SILENT : {1'b0, idx};
   endfunction

endpackage

// File: rtl/note_debounce.sv
// note_debounce: multi-frame debounce of per-frame results.
//   clk_i         : clock, rising edge.
//   reset_i       : synchronous, active-low reset.
//   upd_i         : one-cycle strobe, result_i holds a new frame result.
//   result_i      : candidate code (MSB=1 silent, else bin index).
//   note_o        : committed note index (held through silence).
//   note_valid_o  : 1 = a note is held, 0 = silence.
//   note_update_o : one-cycle pulse the cycle the outputs change.
module note_debounce
   import tuner_pkg::*;
#(
   parameter int STABLE_FRAMES = 3
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              upd_i,
   input  logic [CAND_W-1:0] result_i,
   output logic [IDX_W-1:0]  note_o,
   output logic              note_valid_o,
   output logic              note_update_o
);

   localparam logic [3:0] STABLE_N = 4'(STABLE_FRAMES);

   logic [CAND_W-1:0] cand_q, cand_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [CAND_W-1:0] out_enc;
   logic              commit;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   always_comb begin
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      // Current output in candidate form, so "differs from output" is one compare.
      out_enc = note_valid_o ? {1'b0, note_o} : CAND_SILENT;
      if (upd_i) begin
         if (result_i == cand_q) begin
            cnt_d = sat_inc(cnt_q);
         end else begin
            cand_d = result_i;
            cnt_d  = 4'd1;
         end
         commit = (cnt_d >= STABLE_N) && (result_i != out_enc);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         cand_q        <= CAND_SILENT;
         cnt_q         <= 4'd0;
         note_o        <= '0;
         note_valid_o  <= 1'b0;
         note_update_o <= 1'b0;
      end else begin
         cand_q        <= cand_d;
         cnt_q         <= cnt_d;
         note_update_o <= commit;
         if (commit) begin
            if (result_i[CAND_W-1]) begin
               // Silence keeps the last note index visible.
               note_valid_o <= 1'b0;
            end else begin
               note_o       <= result_i[IDX_W-1:0];
               note_valid_o <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tuner_sched.sv
// tuner_sched: frame-level controller around the 7-bin max_val unit.
//   Collects NUM_BINS magnitudes, presents them to max_val, captures the
//   winning index, then applies a silence threshold and debounce.
//   clk_i          : clock, rising edge.
//   reset_i        : synchronous, active-low reset.
//   mag_i/mag_valid_i/mag_ready_o : upstream bin magnitudes, bin 0 first.
//   mv_data_o/mv_valid_o/mv_ready_i : frame issued to max_val.
//   mv_index_i/mv_valid_i/mv_yumi_o : result returned by max_val.
//   note_o/note_valid_o/note_update_o : debounced note to the UI.
//   err_o          : sticky result-timeout flag (TUNER_SCHED_TIMEOUT_EN only).
// Optional feature macro: TUNER_SCHED_TIMEOUT_EN (WAIT timeout + err_o).
module tuner_sched
   import tuner_pkg::*;
#(
`ifdef TUNER_SCHED_TIMEOUT_EN
   parameter int               TIMEOUT       = 15,
`endif
   parameter int               STABLE_FRAMES = 3,
   parameter logic [MAG_W-1:0] MIN_MAG       = 16'h0100
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic [MAG_W-1:0]                 mag_i,
   input  logic                             mag_valid_i,
   output logic                             mag_ready_o,
   output logic [NUM_BINS-1:0][MAG_W-1:0]   mv_data_o,
   output logic                             mv_valid_o,
   input  logic                             mv_ready_i,
   input  logic [IDX_W-1:0]                 mv_index_i,
   input  logic                             mv_valid_i,
   output logic                             mv_yumi_o,
   output logic [IDX_W-1:0]                 note_o,
   output logic                             note_valid_o,
   output logic                             note_update_o
`ifdef TUNER_SCHED_TIMEOUT_EN
   ,
   output logic                             err_o
`endif
);

   sched_state_e                  state_q, state_d;
   logic [IDX_W-1:0]              cnt_q;
   logic [NUM_BINS-1:0][MAG_W-1:0] buf_q;
   logic [IDX_W-1:0]              win_idx_q;
   logic [MAG_W-1:0]              win_mag_q;
   logic [MAG_W-1:0]              win_sel;
   logic                          mag_fire;
   logic                          last_word;
   logic                          frame_silent;
   logic [CAND_W-1:0]             frame_res;
   logic                          frame_upd;

`ifdef TUNER_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] wait_cnt_q;
   logic            timeout_hit;
   logic            err_q;
`endif

   assign mag_fire  = mag_valid_i && mag_ready_o;
   assign last_word = (cnt_q == IDX_W'(NUM_BINS - 1));

   // Handshake outputs are gated by reset_i so they stay low in the reset cycle.
   always_comb begin
      state_d     = state_q;
      mag_ready_o = 1'b0;
      mv_valid_o  = 1'b0;
      mv_yumi_o   = 1'b0;
`ifdef TUNER_SCHED_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
      case (state_q)
         COLLECT: begin
            mag_ready_o = reset_i;
            if (reset_i && mag_valid_i && last_word) state_d = ISSUE;
         end
         ISSUE: begin
            mv_valid_o = reset_i;
            if (mv_ready_i) state_d = WAIT;
         end
         WAIT: begin
            mv_yumi_o = reset_i;
            if (mv_valid_i) begin
               state_d = UPDATE;
            end
`ifdef TUNER_SCHED_TIMEOUT_EN
            else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               state_d     = COLLECT;
            end
`endif
         end
         UPDATE:  state_d = COLLECT;
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) state_q <= COLLECT;
      else          state_q <= state_d;
   end

   // max_val's index is 3 bits wide; an out-of-range code reads as zero.
   always_comb begin
      win_sel = '0;
      if (mv_index_i < IDX_W'(NUM_BINS)) win_sel = buf_q[mv_index_i];
   end

   // Frame buffer only loads in COLLECT, so it holds from ISSUE through UPDATE.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         cnt_q     <= '0;
         buf_q     <= '0;
         win_idx_q <= '0;
         win_mag_q <= '0;
      end else begin
         if (mag_fire) begin
            buf_q[cnt_q] <= mag_i;
            cnt_q        <= last_word ? '0 : cnt_q + 1'b1;
         end
         if ((state_q == WAIT) && mv_valid_i) begin
            win_idx_q <= mv_index_i;
            win_mag_q <= win_sel;
         end
      end
   end

`ifdef TUNER_SCHED_TIMEOUT_EN
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         wait_cnt_q <= (state_q == WAIT) ? wait_cnt_q + 1'b1 : '0;
         if (timeout_hit) err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`endif

   assign mv_data_o    = buf_q;
   assign frame_silent = (win_mag_q < MIN_MAG);
   assign frame_res    = frame_result(win_idx_q, frame_silent);
   assign frame_upd    = (state_q == UPDATE);

   note_debounce #(
      .STABLE_FRAMES (STABLE_FRAMES)
   ) u_debounce (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .upd_i         (frame_upd),
      .result_i      (frame_res),
      .note_o        (note_o),
      .note_valid_o  (note_valid_o),
      .note_update_o (note_update_o)
   );

endmodule

// File: doc/tuner_sched.md
Name: tuner_sched

Overview:
- Frame-level controller for the 7-bin max-index unit (`max_val`).
- Collects one frame of 7 bin magnitudes from the upstream filter bank, holds them stable and issues them to `max_val` with its valid/ready handshake, then captures the winning index.
- Applies a silence threshold and multi-frame debounce; outputs the stable detected note to the display/UI logic.

Parameters:
- NUM_BINS, 7, bins per frame; fixed to match `max_val`, other values unsupported.
- MAG_W, 16, magnitude width in bits.
- STABLE_FRAMES, 3, consecutive identical frame results needed before `note_o` changes; legal range 1..15.
- MIN_MAG, 16'h0100, a winner magnitude below this makes the frame "silent".
- TIMEOUT, 15, max cycles waiting for a `max_val` result; used only with the optional feature.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- reset_i  in  1  synchronous, active-low reset; the parent inverts it for `max_val`, whose reset is active-high.
- mag_i  in  MAG_W  bin magnitude; bin 0 first.
- mag_valid_i  in  1  mag_i valid.
- mag_ready_o  out  1  ready for mag_i.
- mv_data_o  out  MAG_W x NUM_BINS  frame buffer, drives `max_val` data_i.
- mv_valid_o  out  1  to `max_val` valid_i.
- mv_ready_i  in  1  from `max_val` ready_o.
- mv_index_i  in  3  from `max_val` index_o.
- mv_valid_i  in  1  from `max_val` valid_o.
- mv_yumi_o  out  1  to `max_val` ready_i.
- note_o  out  3  stable note index.
- note_valid_o  out  1  1 = a note is held; 0 = silence.
- note_update_o  out  1  one-cycle pulse whenever note_o or note_valid_o changes.

Behaviour:
- States: COLLECT, ISSUE, WAIT, UPDATE. Reset (reset_i==0 at a clock edge) applies the following:
  - state=COLLECT and word count=0.
  - Buffer cleared to 0, candidate=silent, stable count=0.
  - note_o=0, note_valid_o=0, note_update_o=0.
  - mv_valid_o=0, mv_yumi_o=0, mag_ready_o=0 for the reset cycle.
- COLLECT:
  - mag_ready_o=1.
  - Each mag_valid_i&&mag_ready_o writes buffer[count] and increments count.
  - The write with count==NUM_BINS-1 sets count=0 and moves to ISSUE.
  - Gaps in mag_valid_i are allowed.
- ISSUE:
  - mv_valid_o=1 and mag_ready_o=0.
  - On mv_valid_o&&mv_ready_i, move to WAIT; mv_valid_o is 0 from the next cycle.
- WAIT:
  - mv_yumi_o=1.
  - On mv_valid_i, capture mv_index_i and the winner magnitude (buffer[mv_index_i]), then move to UPDATE.
  - Nominal latency from issue handshake to result is 3 cycles.
- Buffer must stay unchanged from ISSUE entry until UPDATE. `max_val` re-reads data_i in its later stages.
- UPDATE (1 cycle), then return to COLLECT:
  - Frame result r = silent if the winner magnitude < MIN_MAG (unsigned compare); otherwise r = the captured index.
  - If r == candidate, stable count increments, saturating at 15. Otherwise candidate=r and count=1.
  - Commit when count reaches STABLE_FRAMES and r differs from the current output. Silent commits note_valid_o=0 with note_o held. Any other r sets note_o=r and note_valid_o=1.
  - On commit, note_update_o pulses in the cycle after UPDATE.
- Ties are resolved by `max_val` (lowest index wins); this block does not re-resolve them.
- Frame-to-frame throughput is NUM_BINS + ISSUE + 3 + 1 cycles minimum.
- Reset mid-frame discards the partial frame and any in-flight `max_val` result.

Optional Feature:
- Macro TUNER_SCHED_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WAIT.
  - If mv_valid_i has not arrived after TIMEOUT cycles, the frame is dropped: no debounce update, return to COLLECT.
  - Added output err_o (1 bit) is set sticky and cleared only by reset.
- When undefined: WAIT waits indefinitely, and err_o does not exist.

Decomposition:
- Package `tuner_pkg` holds:
  - NUM_BINS and MAG_W constants.
  - The state enum `sched_state_e`.
  - A silent encoding for the candidate: a 4-bit candidate whose MSB=1 means silent.
- One natural sub-module, `note_debounce`: candidate register, saturating counter and commit/pulse logic.
- Frame buffer and FSM stay in `tuner_sched`.

Test Plan:
- Reset, then frame {10,20,300,40,50,60,70} → after the 3rd identical frame, note_o=2, note_valid_o=1, note_update_o high for 1 cycle. Frames 1–2 produce no change.
- Established note 2, then 2 frames winning index 5 followed by 1 frame winning 2 → no output change, candidate resets each time.
- All bins equal to 16'h0080 (below MIN_MAG) for 3 frames after note 2 → note_valid_o=0, note_o stays 2, one update pulse.
- Tie: bins 1 and 4 both 16'h0500, others 0 → index 1 reported; buffer verified constant through WAIT.
- mag_valid_i toggled randomly, plus a mid-frame reset after 4 words → the next full frame is collected from bin 0, and no note changes from the aborted data.
- TUNER_SCHED_TIMEOUT_EN with mv_valid_i tied 0 → returns to COLLECT after 15 WAIT cycles, err_o=1 and stays 1, note_o unchanged.
